// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_pkg;

  typedef enum logic [1:0] {
    ROT_L  = 2'd0,
    ROT_R  = 2'd1,
    BOUNCE = 2'd2,
    BLINK  = 2'd3
  } led_mode_e;

  localparam int unsigned LED_MAX_NUM = 32;

  // 0.5 s at a 50 MHz board clock
  localparam logic [24:0] LED_DEFAULT_PERIOD = 25'd25_000_000;

endpackage

// File: rtl/led_prescaler.sv
// Step-rate prescaler: counts enabled cycles and flags the last one of each period.
module led_prescaler #(
  parameter int unsigned CNT_W = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] last_cnt;

  // Terminal test is >= so a period shrunk below the running count steps at once.
  always_comb begin
    last_cnt = (period == '0) ? '0 : period - CNT_W'(1);
    tick     = en && (cnt_q >= last_cnt);
    cnt_d    = cnt_q;
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern generator: rotate left/right, bounce and blink, one step per prescaler tick.
module led_sequencer
  import led_pkg::*;
#(
  parameter int unsigned NUM_LED = 8,
  parameter int unsigned CNT_W   = 25
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   period,
  output logic [NUM_LED-1:0] led,
  output logic               step_pulse
);

  localparam logic [NUM_LED-1:0] LED_ONE = NUM_LED'(1);
  localparam logic               DIR_UP  = 1'b1;
  localparam logic               DIR_DN  = 1'b0;

  logic               tick;
  logic [NUM_LED-1:0] led_q, led_d;
  logic               dir_q, dir_d;
  led_mode_e          cur_mode_q, cur_mode_d;
  logic               step_pulse_q, step_pulse_d;
  led_mode_e          mode_sel;
  logic [NUM_LED-1:0] rot_l, rot_r, shift_up, shift_dn;

  led_prescaler #(
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .period (period),
    .tick   (tick)
  );

  // Shift-based rotates degenerate to a hold when NUM_LED is 1.
  always_comb begin
    mode_sel = led_mode_e'(mode);
    rot_l    = (led_q << 1) | (led_q >> (NUM_LED - 1));
    rot_r    = (led_q >> 1) | (led_q << (NUM_LED - 1));
    shift_up = led_q << 1;
    shift_dn = led_q >> 1;

    led_d        = led_q;
    dir_d        = dir_q;
    cur_mode_d   = cur_mode_q;
    step_pulse_d = tick;

    if (tick) begin
      if (mode_sel != cur_mode_q) begin
        cur_mode_d = mode_sel;
        led_d      = (mode_sel == BLINK) ? '1 : LED_ONE;
        if (mode_sel == BOUNCE) begin
          dir_d = DIR_UP;
        end
      end else begin
        unique case (cur_mode_q)
          ROT_L:  led_d = rot_l;
          ROT_R:  led_d = rot_r;
          BLINK:  led_d = ~led_q;
          BOUNCE: begin
            if (NUM_LED == 1) begin
              led_d = led_q;
            end else if (dir_q == DIR_UP) begin
              led_d = shift_up;
              if (shift_up[NUM_LED-1]) begin
                dir_d = DIR_DN;
              end
            end else begin
              led_d = shift_dn;
              if (shift_dn[0]) begin
                dir_d = DIR_UP;
              end
            end
          end
          default: led_d = led_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q        <= LED_ONE;
      dir_q        <= DIR_UP;
      cur_mode_q   <= ROT_L;
      step_pulse_q <= 1'b0;
    end else begin
      led_q        <= led_d;
      dir_q        <= dir_d;
      cur_mode_q   <= cur_mode_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign led        = led_q;
  assign step_pulse = step_pulse_q;

endmodule
